// File: rtl/width_conv_pkg.sv
// Shared widths for the 128<->24 bit width converters.
// Group constants describe the 3-in / 16-out alignment period.
package width_conv_pkg;
   localparam int IN_W                = 128;
   localparam int OUT_W               = 24;
   localparam int BUF_W               = IN_W + OUT_W;
   localparam int CNT_W               = $clog2(BUF_W + 1);
   localparam int WORDS_PER_GROUP_IN  = 3;
   localparam int WORDS_PER_GROUP_OUT = 16;
endpackage

// File: rtl/width_128to24.sv
// Unpacks 128-bit words into 24-bit words MSB-first, carrying bits across words.
// Define WIDTH_128TO24_OVERLAP_EN to allow push and pop in the same cycle (no bubble).
module width_128to24 #(
   parameter int IN_W  = width_conv_pkg::IN_W,
   parameter int OUT_W = width_conv_pkg::OUT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [IN_W-1:0]  data_in,
   output logic             valid_out,
   input  logic             ready_out,
   output logic [OUT_W-1:0] data_out
);
   localparam int BUF_W = IN_W + OUT_W;
   localparam int CNT_W = $clog2(BUF_W + 1);
   localparam logic [CNT_W-1:0] C_IN   = CNT_W'(IN_W);
   localparam logic [CNT_W-1:0] C_OUT  = CNT_W'(OUT_W);
   localparam logic [CNT_W-1:0] C_2OUT = CNT_W'(2 * OUT_W);

   logic [BUF_W-1:0] r_buf;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid_out;

   logic             w_push, w_pop;
   logic [BUF_W-1:0] w_buf_sh, w_buf_nx;
   logic [CNT_W-1:0] w_cnt_sh, w_cnt_nx;

`ifdef WIDTH_128TO24_OVERLAP_EN
   assign ready_in = (r_cnt < C_OUT) || (r_cnt < C_2OUT && r_valid_out && ready_out);
`else
   assign ready_in = (r_cnt < C_OUT);
`endif

   assign w_push    = valid_in && ready_in;
   assign w_pop     = r_valid_out && ready_out;
   assign valid_out = r_valid_out;
   assign data_out  = r_buf[BUF_W-1 -: OUT_W];

   // Pop first, then append the new word directly below the surviving valid bits.
   always_comb begin
      w_buf_sh = w_pop ? (r_buf << OUT_W) : r_buf;
      w_cnt_sh = w_pop ? (r_cnt - C_OUT) : r_cnt;
      w_buf_nx = w_buf_sh;
      w_cnt_nx = w_cnt_sh;
      if (w_push) begin
         w_buf_nx = w_buf_sh | ({data_in, {OUT_W{1'b0}}} >> w_cnt_sh);
         w_cnt_nx = w_cnt_sh + C_IN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf       <= '0;
         r_cnt       <= '0;
         r_valid_out <= 1'b0;
      end else begin
         r_buf       <= w_buf_nx;
         r_cnt       <= w_cnt_nx;
         r_valid_out <= (w_cnt_nx >= C_OUT);
      end
   end
endmodule
